// File: rtl/hms_up_counter.sv
// ---------------------------------------------------------------------------
// hms_up_counter
//
// Up-counting time-of-day core. A prescaler divides clk into one tick every
// TICK_DIV enabled cycles; each tick advances seconds, minutes and hours
// (wrapping at 59, 59 and HOUR_MAX) in a single cycle, with carry pulses
// reported alongside. A rising edge on load sets the time after a range
// check, acknowledged by load_ack or rejected by load_err.
//
// Parameters:
//   TICK_DIV  clk cycles per seconds tick (>= 2)
//   HOUR_MAX  last hour value before the hour wraps to 0 (1..31)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   run; low freezes prescaler and counters
//   load       in   time-set request, acted on at its 0->1 transition
//   load_sec   in   [5:0] seconds to load
//   load_min   in   [5:0] minutes to load
//   load_hr    in   [4:0] hours to load
//   load_ack   out  one-cycle pulse: load accepted
//   load_err   out  one-cycle pulse: load rejected (field out of range)
//   sec        out  [5:0] current seconds 0..59
//   min        out  [5:0] current minutes 0..59
//   hr         out  [4:0] current hours 0..HOUR_MAX
//   sec_tick   out  one-cycle pulse when sec advances from a tick
//   min_carry  out  one-cycle pulse when sec wraps 59->0
//   day_carry  out  one-cycle pulse when time wraps HOUR_MAX:59:59 -> 0:0:0
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module hms_up_counter #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hr,
    output logic       load_ack,
    output logic       load_err,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       sec_tick,
    output logic       min_carry,
    output logic       day_carry
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
    localparam logic [5:0] SecLast = 6'd59;
    localparam logic [5:0] MinLast = 6'd59;
    localparam logic [4:0] HrLast  = 5'(HOUR_MAX);

    // State
    logic [PreW-1:0] pre_q, pre_d;
    logic            load_q;
    logic            armed_q, armed_d;
    logic [5:0]      sec_q, sec_d;
    logic [5:0]      min_q, min_d;
    logic [4:0]      hr_q, hr_d;
    logic            sec_tick_q, sec_tick_d;
    logic            min_carry_q, min_carry_d;
    logic            day_carry_q, day_carry_d;
    logic            load_ack_q, load_ack_d;
    logic            load_err_q, load_err_d;

    // Decoded conditions
    logic tick;
    logic load_req;
    logic load_ok;

    always_comb begin
        tick     = enable && (pre_q == PreLast);
        // armed_q keeps a load held high across reset from being seen as a
        // fresh request: load must be observed low at least once first.
        load_req = load && !load_q && armed_q;
        load_ok  = (load_sec <= SecLast) && (load_min <= MinLast) && (load_hr <= HrLast);
    end

    always_comb begin
        pre_d       = pre_q;
        armed_d     = armed_q | ~load;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        sec_tick_d  = 1'b0;
        min_carry_d = 1'b0;
        day_carry_d = 1'b0;
        load_ack_d  = 1'b0;
        load_err_d  = 1'b0;

        // Prescaler runs independently of load; a valid load overrides it below.
        if (enable) begin
            pre_d = tick ? '0 : pre_q + PreW'(1);
        end

        if (load_req) begin
            // Load wins over a coincident tick; the tick is simply dropped.
            if (load_ok) begin
                sec_d      = load_sec;
                min_d      = load_min;
                hr_d       = load_hr;
                pre_d      = '0;
                load_ack_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            sec_tick_d = 1'b1;
            if (sec_q == SecLast) begin
                sec_d       = '0;
                min_carry_d = 1'b1;
                if (min_q == MinLast) begin
                    min_d = '0;
                    if (hr_q == HrLast) begin
                        hr_d        = '0;
                        day_carry_d = 1'b1;
                    end else begin
                        hr_d = hr_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            load_q      <= 1'b0;
            armed_q     <= 1'b0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            sec_tick_q  <= 1'b0;
            min_carry_q <= 1'b0;
            day_carry_q <= 1'b0;
            load_ack_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            load_q      <= load;
            armed_q     <= armed_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            sec_tick_q  <= sec_tick_d;
            min_carry_q <= min_carry_d;
            day_carry_q <= day_carry_d;
            load_ack_q  <= load_ack_d;
            load_err_q  <= load_err_d;
        end
    end

    always_comb begin
        sec       = sec_q;
        min       = min_q;
        hr        = hr_q;
        sec_tick  = sec_tick_q;
        min_carry = min_carry_q;
        day_carry = day_carry_q;
        load_ack  = load_ack_q;
        load_err  = load_err_q;
    end

endmodule

// File: tb/tb_hms_up_counter.sv
module tb_hms_up_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hr;
    logic       load_ack;
    logic       load_err;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       sec_tick;
    logic       min_carry;
    logic       day_carry;

    int checks = 0;
    int errors = 0;

    hms_up_counter #(
        .TICK_DIV(4),
        .HOUR_MAX(23)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .load_sec (load_sec),
        .load_min (load_min),
        .load_hr  (load_hr),
        .load_ack (load_ack),
        .load_err (load_err),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .sec_tick (sec_tick),
        .min_carry(min_carry),
        .day_carry(day_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        load_sec = '0; load_min = '0; load_hr = '0;
        step(3);
        checks++;
        if ({hr, min, sec} !== 17'd0) begin
            errors++;
            $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hr, min, sec);
        end
        checks++;
        if ({sec_tick, min_carry, day_carry, load_ack, load_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 00000",
                     {sec_tick, min_carry, day_carry, load_ack, load_err});
        end
        reset = 1'b0;
    endtask

    task automatic test_count();
        enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            checks++;
            if (sec_tick !== ((c % 4) == 0)) begin
                errors++;
                $display("FAIL count_tick c=%0d: got %b want %b", c, sec_tick, (c % 4) == 0);
            end
            checks++;
            if ({min_carry, day_carry} !== 2'b00) begin
                errors++;
                $display("FAIL count_carry c=%0d: got %b want 00", c, {min_carry, day_carry});
            end
        end
        checks++;
        if ({hr, min, sec} !== {5'd0, 6'd0, 6'd3}) begin
            errors++;
            $display("FAIL count_time: got %0d:%0d:%0d want 0:0:3", hr, min, sec);
        end
        enable = 1'b0;
    endtask

    task automatic test_load_carry();
        load_sec = 6'd59; load_min = 6'd0; load_hr = 5'd0;
        enable = 1'b1; load = 1'b1;
        step(1);
        checks++;
        if (load_ack !== 1'b1 || sec !== 6'd59) begin
            errors++;
            $display("FAIL load_ack: got ack=%b sec=%0d want ack=1 sec=59", load_ack, sec);
        end
        load = 1'b0;
        step(1);
        checks++;
        if (load_ack !== 1'b0) begin
            errors++;
            $display("FAIL load_ack_pulse: got %b want 0", load_ack);
        end
        step(2);
        checks++;
        if (sec_tick !== 1'b0 || sec !== 6'd59) begin
            errors++;
            $display("FAIL carry_early: got tick=%b sec=%0d want tick=0 sec=59", sec_tick, sec);
        end
        step(1);
        checks++;
        if ({sec_tick, min_carry, day_carry} !== 3'b110 || sec !== 6'd0 || min !== 6'd1
            || hr !== 5'd0) begin
            errors++;
            $display("FAIL min_carry: got pulses=%b %0d:%0d:%0d want 110 0:1:0",
                     {sec_tick, min_carry, day_carry}, hr, min, sec);
        end
        step(1);
        checks++;
        if ({sec_tick, min_carry} !== 2'b00) begin
            errors++;
            $display("FAIL min_carry_pulse: got %b want 00", {sec_tick, min_carry});
        end
        enable = 1'b0;
    endtask

    task automatic test_day_wrap();
        load_sec = 6'd59; load_min = 6'd59; load_hr = 5'd23;
        load = 1'b1;
        step(1);
        checks++;
        if (load_ack !== 1'b1 || {hr, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
            errors++;
            $display("FAIL day_load: got ack=%b %0d:%0d:%0d want ack=1 23:59:59",
                     load_ack, hr, min, sec);
        end
        load = 1'b0; enable = 1'b1;
        step(3);
        checks++;
        if ({sec_tick, min_carry, day_carry} !== 3'b000 || sec !== 6'd59) begin
            errors++;
            $display("FAIL day_early: got pulses=%b sec=%0d want 000 sec=59",
                     {sec_tick, min_carry, day_carry}, sec);
        end
        step(1);
        checks++;
        if ({sec_tick, min_carry, day_carry} !== 3'b111 || {hr, min, sec} !== 17'd0) begin
            errors++;
            $display("FAIL day_wrap: got pulses=%b %0d:%0d:%0d want 111 0:0:0",
                     {sec_tick, min_carry, day_carry}, hr, min, sec);
        end
        step(1);
        checks++;
        if ({sec_tick, min_carry, day_carry} !== 3'b000 || {hr, min, sec} !== 17'd0) begin
            errors++;
            $display("FAIL day_after: got pulses=%b %0d:%0d:%0d want 000 0:0:0",
                     {sec_tick, min_carry, day_carry}, hr, min, sec);
        end
        enable = 1'b0;
    endtask

    task automatic test_load_err();
        // Known starting point: valid load clears the prescaler, then 2 enabled cycles.
        load_sec = 6'd10; load_min = 6'd0; load_hr = 5'd0;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        load_sec = 6'd0; load_min = 6'd60; load_hr = 5'd0;
        load = 1'b1;
        step(1);
        checks++;
        if (load_err !== 1'b1 || load_ack !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got err=%b ack=%b want err=1 ack=0", load_err, load_ack);
        end
        checks++;
        if ({hr, min, sec} !== {5'd0, 6'd0, 6'd10}) begin
            errors++;
            $display("FAIL err_time: got %0d:%0d:%0d want 0:0:10", hr, min, sec);
        end
        for (int c = 0; c < 10; c++) begin
            step(1);
            checks++;
            if ({load_err, load_ack} !== 2'b00) begin
                errors++;
                $display("FAIL err_hold c=%0d: got err=%b ack=%b want 0 0", c, load_err, load_ack);
            end
        end
        load = 1'b0; enable = 1'b1;
        step(1);
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL err_pre_early: got tick=%b want 0", sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || sec !== 6'd11) begin
            errors++;
            $display("FAIL err_pre_kept: got tick=%b sec=%0d want tick=1 sec=11", sec_tick, sec);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_hold();
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step(1);
            checks++;
            if (sec_tick !== 1'b0 || sec !== 6'd11) begin
                errors++;
                $display("FAIL hold c=%0d: got tick=%b sec=%0d want tick=0 sec=11",
                         c, sec_tick, sec);
            end
        end
        enable = 1'b1;
        step(1);
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_early: got tick=%b want 0", sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || sec !== 6'd12) begin
            errors++;
            $display("FAIL resume_tick: got tick=%b sec=%0d want tick=1 sec=12", sec_tick, sec);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_sec = 6'd20; load_min = 6'd10; load_hr = 5'd5;
        load = 1'b1;
        step(1);
        checks++;
        if (load_ack !== 1'b1 || {hr, min, sec} !== {5'd5, 6'd10, 6'd20}) begin
            errors++;
            $display("FAIL mid_load: got ack=%b %0d:%0d:%0d want ack=1 5:10:20",
                     load_ack, hr, min, sec);
        end
        enable = 1'b1;
        step(1);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({hr, min, sec} !== 17'd0 || {sec_tick, min_carry, day_carry, load_ack, load_err}
            !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %0d:%0d:%0d pulses=%b want 0:0:0 00000", hr, min, sec,
                     {sec_tick, min_carry, day_carry, load_ack, load_err});
        end
        step(2);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            checks++;
            if ({load_ack, load_err} !== 2'b00) begin
                errors++;
                $display("FAIL held_load c=%0d: got ack=%b err=%b want 0 0", c, load_ack, load_err);
            end
        end
        checks++;
        if ({hr, min, sec} !== {5'd0, 6'd0, 6'd1}) begin
            errors++;
            $display("FAIL post_reset_time: got %0d:%0d:%0d want 0:0:1", hr, min, sec);
        end
        enable = 1'b0; load = 1'b0;
        step(1);
        load = 1'b1;
        step(1);
        checks++;
        if (load_ack !== 1'b1 || {hr, min, sec} !== {5'd5, 6'd10, 6'd20}) begin
            errors++;
            $display("FAIL reload: got ack=%b %0d:%0d:%0d want ack=1 5:10:20",
                     load_ack, hr, min, sec);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_load_carry();
        test_day_wrap();
        test_load_err();
        test_enable_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
